cpu_bus_responder: RTL and testbench



---
 rtl/bus_pkg.sv | 25 ++
 rtl/write_post_buffer.sv | 45 ++++
 rtl/cpu_bus_responder.sv | 162 ++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg : shared types and memory-map constants for the CPU bus responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WSTALL = 3'd1,
    WREQ   = 3'd2,
    RPEND  = 3'd3,
    RSTALL = 3'd4,
    RREQ   = 3'd5
  } state_t;

  // Value returned to the CPU when a read is abandoned on timeout.
  localparam logic [7:0]  MEM_IDLE_DATA    = 8'hFF;
  // Hardware register / ROM area, served with extra wait states.
  localparam logic [15:0] SLOW_REGION_BASE = 16'hD000;

endpackage

`default_nettype wire

// File: rtl/write_post_buffer.sv
// ---------------------------------------------------------------------------
// write_post_buffer : one-entry posted-write store with sticky overrun flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module write_post_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic        clear,
  output logic        valid,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        overrun
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid   <= 1'b0;
      addr    <= 16'h0000;
      data    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end
      // A full buffer (judged before this clock's clear) drops the new write.
      if (load) begin
        if (valid) begin
          overrun <= 1'b1;
        end else begin
          valid <= 1'b1;
          addr  <= load_addr;
          data  <= load_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder : 6502C bus cycle responder in front of a single-port memory
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] SLOW_BASE   = SLOW_REGION_BASE,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cycleStart,
  input  logic [15:0] addr,
  input  logic        RW,
  input  logic [7:0]  dataFromCPU,
  output logic [7:0]  dataToCPU,
  output logic        dataValid,
  output logic        RDY,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busError,
  output logic        overrun
);

  localparam int WW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST    = WW'(WAIT_STATES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  state_t        state, next;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   rd_addr;
  logic [15:0]   rd_addr_now;
  logic          rd_start, wr_start, rd_waiting;
  logic          wait_done, timeout, retire;
  logic          wb_valid, wb_clear;
  logic [15:0]   wb_addr;
  logic [7:0]    wb_data;

  function automatic state_t wr_path(input logic [15:0] a);
    return (WAIT_STATES != 0 && a >= SLOW_BASE) ? WSTALL : WREQ;
  endfunction

  function automatic state_t rd_path(input logic [15:0] a);
    return (WAIT_STATES != 0 && a >= SLOW_BASE) ? RSTALL : RREQ;
  endfunction

  // RDY low means a read is outstanding; new cycles are ignored meanwhile.
  assign rd_start    = cycleStart && RW && RDY;
  assign wr_start    = cycleStart && !RW && RDY;
  assign rd_waiting  = !RDY || rd_start;
  assign rd_addr_now = RDY ? addr : rd_addr;

  assign mem_req   = (state == WREQ) || (state == RREQ);
  assign mem_we    = (state == WREQ);
  assign wait_done = (wait_cnt == WAIT_LAST);
  assign timeout   = mem_req && !mem_ack && (tmo_cnt == TIMEOUT_LAST);
  assign retire    = mem_req && (mem_ack || timeout);

  write_post_buffer u_wbuf (
    .clock     (clock),
    .reset     (reset),
    .load      (wr_start),
    .load_addr (addr),
    .load_data (dataFromCPU),
    .clear     (wb_clear),
    .valid     (wb_valid),
    .addr      (wb_addr),
    .data      (wb_data),
    .overrun   (overrun)
  );

  always_comb begin
    next     = state;
    wb_clear = 1'b0;
    case (state)
      IDLE: begin
        if (wb_valid) begin
          next = rd_start ? RPEND : wr_path(wb_addr);
        end else if (rd_start) begin
          next = rd_path(addr);
        end
      end
      RPEND:  next = wb_valid ? wr_path(wb_addr) : rd_path(rd_addr);
      WSTALL: if (wait_done) next = WREQ;
      RSTALL: if (wait_done) next = RREQ;
      WREQ: begin
        if (retire) begin
          wb_clear = 1'b1;
          next     = rd_waiting ? rd_path(rd_addr_now) : IDLE;
        end
      end
      RREQ:    if (retire) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      RDY       <= 1'b1;
      dataValid <= 1'b0;
      dataToCPU <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      busError  <= 1'b0;
      rd_addr   <= 16'h0000;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= next;
      dataValid <= 1'b0;

      if (rd_start) begin
        rd_addr <= addr;
        RDY     <= 1'b0;
      end

      if (state == RREQ && retire) begin
        dataToCPU <= mem_ack ? mem_rdata : MEM_IDLE_DATA;
        dataValid <= 1'b1;
        RDY       <= 1'b1;
      end

      if (timeout) begin
        busError <= 1'b1;
      end

      // Request address/data are only reloaded on entry to or stay in a REQ state.
      if (next == WREQ) begin
        mem_addr  <= wb_addr;
        mem_wdata <= wb_data;
      end else if (next == RREQ) begin
        mem_addr  <= rd_addr_now;
      end

      if ((state == WSTALL || state == RSTALL) && !wait_done) begin
        wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (mem_req && !mem_ack && !timeout) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_responder : directed self-checking bench for cpu_bus_responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_bus_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cycleStart = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        RW = 1'b1;
  logic [7:0]  dataFromCPU = 8'h00;
  logic [7:0]  dataToCPU;
  logic        dataValid;
  logic        RDY;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busError;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  cpu_bus_responder #(
    .WAIT_STATES (2),
    .SLOW_BASE   (16'hD000),
    .TIMEOUT     (15)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cycleStart  (cycleStart),
    .addr        (addr),
    .RW          (RW),
    .dataFromCPU (dataFromCPU),
    .dataToCPU   (dataToCPU),
    .dataValid   (dataValid),
    .RDY         (RDY),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busError    (busError),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    chk("reset_rdy",      16'(RDY),       16'h1);
    chk("reset_req",      16'(mem_req),   16'h0);
    chk("reset_we",       16'(mem_we),    16'h0);
    chk("reset_valid",    16'(dataValid), 16'h0);
    chk("reset_data",     16'(dataToCPU), 16'h00);
    chk("reset_maddr",    mem_addr,       16'h0000);
    chk("reset_wdata",    16'(mem_wdata), 16'h00);
    chk("reset_buserr",   16'(busError),  16'h0);
    chk("reset_overrun",  16'(overrun),   16'h0);

    // Stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    chk("stray_valid", 16'(dataValid), 16'h0);
    chk("stray_rdy",   16'(RDY),       16'h1);

    // Fast read of 0x0200, ack on first request clock
    cycleStart = 1'b1; RW = 1'b1; addr = 16'h0200;
    tick();
    cycleStart = 1'b0;
    chk("fast_rdy_low", 16'(RDY),     16'h0);
    chk("fast_req",     16'(mem_req), 16'h1);
    chk("fast_we",      16'(mem_we),  16'h0);
    chk("fast_maddr",   mem_addr,     16'h0200);
    mem_ack = 1'b1; mem_rdata = 8'hA9;
    tick();
    mem_ack = 1'b0;
    chk("fast_valid", 16'(dataValid), 16'h1);
    chk("fast_rdy",   16'(RDY),       16'h1);
    chk("fast_data",  16'(dataToCPU), 16'hA9);
    chk("fast_req_drop", 16'(mem_req), 16'h0);
    tick();
    chk("fast_pulse_end", 16'(dataValid), 16'h0);

    // Slow read of 0xD40B: mem_req rises 3 clocks after cycleStart
    cycleStart = 1'b1; RW = 1'b1; addr = 16'hD40B;
    tick();
    cycleStart = 1'b0;
    chk("slow_req_c1", 16'(mem_req), 16'h0);
    chk("slow_rdy_c1", 16'(RDY),     16'h0);
    tick();
    chk("slow_req_c2", 16'(mem_req), 16'h0);
    chk("slow_rdy_c2", 16'(RDY),     16'h0);
    tick();
    chk("slow_req_c3", 16'(mem_req), 16'h1);
    chk("slow_maddr",  mem_addr,     16'hD40B);
    chk("slow_rdy_c3", 16'(RDY),     16'h0);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    chk("slow_valid", 16'(dataValid), 16'h1);
    chk("slow_data",  16'(dataToCPU), 16'h3C);
    chk("slow_rdy",   16'(RDY),       16'h1);
    tick();

    // Write 0x55 to 0x0300, read 0x0300 two clocks later
    cycleStart = 1'b1; RW = 1'b0; addr = 16'h0300; dataFromCPU = 8'h55;
    tick();
    cycleStart = 1'b0;
    chk("wr_rdy_high", 16'(RDY),     16'h1);
    chk("wr_no_req",   16'(mem_req), 16'h0);
    tick();
    chk("wr_req",   16'(mem_req),   16'h1);
    chk("wr_we",    16'(mem_we),    16'h1);
    chk("wr_maddr", mem_addr,       16'h0300);
    chk("wr_wdata", 16'(mem_wdata), 16'h55);
    cycleStart = 1'b1; RW = 1'b1; addr = 16'h0300;
    tick();
    cycleStart = 1'b0;
    chk("rbw_rdy_low", 16'(RDY),    16'h0);
    chk("rbw_still_w", 16'(mem_we), 16'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rbw_rd_req",  16'(mem_req), 16'h1);
    chk("rbw_rd_we",   16'(mem_we),  16'h0);
    chk("rbw_rd_addr", mem_addr,     16'h0300);
    mem_ack = 1'b1; mem_rdata = 8'h55;
    tick();
    mem_ack = 1'b0;
    chk("rbw_valid", 16'(dataValid), 16'h1);
    chk("rbw_data",  16'(dataToCPU), 16'h55);
    chk("rbw_rdy",   16'(RDY),       16'h1);
    tick();

    // Back-to-back writes with ack held off: second dropped
    cycleStart = 1'b1; RW = 1'b0; addr = 16'h0400; dataFromCPU = 8'h11;
    tick();
    addr = 16'h0404; dataFromCPU = 8'h22;
    tick();
    cycleStart = 1'b0;
    chk("ovr_flag",  16'(overrun),   16'h1);
    chk("ovr_req",   16'(mem_req),   16'h1);
    chk("ovr_maddr", mem_addr,       16'h0400);
    chk("ovr_wdata", 16'(mem_wdata), 16'h11);
    tick();
    chk("ovr_hold_wdata", 16'(mem_wdata), 16'h11);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ovr_done_req", 16'(mem_req), 16'h0);
    tick();
    chk("ovr_no_second", 16'(mem_req), 16'h0);
    chk("ovr_sticky",    16'(overrun), 16'h1);

    // Read with no ack: 15 request clocks then abort
    cycleStart = 1'b1; RW = 1'b1; addr = 16'h0500;
    tick();
    cycleStart = 1'b0;
    chk("tmo_req_start", 16'(mem_req), 16'h1);
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_req_c15", 16'(mem_req), 16'h1);
    chk("tmo_err_c15", 16'(busError), 16'h0);
    tick();
    chk("tmo_req_drop", 16'(mem_req),   16'h0);
    chk("tmo_buserr",   16'(busError),  16'h1);
    chk("tmo_data",     16'(dataToCPU), 16'hFF);
    chk("tmo_valid",    16'(dataValid), 16'h1);
    chk("tmo_rdy",      16'(RDY),       16'h1);
    tick();

    // Reset during RREQ
    cycleStart = 1'b1; RW = 1'b1; addr = 16'h0600;
    tick();
    cycleStart = 1'b0;
    chk("rst_in_rreq", 16'(mem_req), 16'h1);
    reset = 1'b1;
    tick();
    chk("rst_rdy",     16'(RDY),       16'h1);
    chk("rst_req",     16'(mem_req),   16'h0);
    chk("rst_buserr",  16'(busError),  16'h0);
    chk("rst_overrun", 16'(overrun),   16'h0);
    chk("rst_data",    16'(dataToCPU), 16'h00);
    reset = 1'b0;
    tick();
    chk("rst_idle_req", 16'(mem_req), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
